pe_row_feeder: RTL and testbench

- Sequencer that drives one processing element (PE) through a 1-D row convolution and collects its results.
- Holds a filter row and an ifmap row, then issues one filter×ifmap pair per cycle to the PE in filter-reuse mode.
- Latency-matches the PE's 2-cycle product output and accumulates products into per-output psums.
- Emits finished psums on a valid/ready stream. It sits between the global buffer and the PE.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_tag_pipe.sv | 39 +++
 rtl/pe_row_feeder.sv | 190 +++++++++++++++++++
 tb/tb_pe_row_feeder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE row feeder: PE mode encodings, feeder states
// and the fixed product latency of the processing element.
package pe_pkg;

    localparam logic [1:0] MODE_FILTER = 2'b00;
    localparam logic [1:0] MODE_IFMAP  = 2'b01;
    localparam logic [1:0] MODE_ACC    = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    localparam int PE_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        FLUSH = 2'b10,
        EMIT  = 2'b11
    } feeder_state_t;

endpackage

// File: rtl/pe_tag_pipe.sv
// Delay line of {valid, idx} tags matching the PE product latency, so each
// product returning on pe_psum_in is paired with its output position.
module pe_tag_pipe
    import pe_pkg::*;
#(
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);

    logic          vld [PE_LATENCY];
    logic [IW-1:0] idx [PE_LATENCY];

    // shift tags one stage per cycle; reset empties the pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PE_LATENCY; i++) begin
                vld[i] <= 1'b0;
                idx[i] <= {IW{1'b0}};
            end
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < PE_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[PE_LATENCY-1];
    assign out_idx   = idx[PE_LATENCY-1];

endmodule

// File: rtl/pe_row_feeder.sv
// Drives one PE through a 1-D row convolution in filter-reuse order, sums the
// returned products per output position and streams the finished psums out.
module pe_row_feeder
    import pe_pkg::*;
#(
    parameter int DW = 32,
    parameter int S  = 3,
    parameter int W  = 8,
    localparam int E  = W - S + 1,
    localparam int WA = (S > 1) ? $clog2(S) : 1,
    localparam int IA = (W > 1) ? $clog2(W) : 1,
    localparam int EA = (E > 1) ? $clog2(E) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wt_wr_en,
    input  logic [WA-1:0] wt_wr_addr,
    input  logic [DW-1:0] wt_wr_data,
    input  logic          if_wr_en,
    input  logic [IA-1:0] if_wr_addr,
    input  logic [DW-1:0] if_wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    pe_mode,
    output logic [DW-1:0] pe_filter_data,
    output logic [DW-1:0] pe_ifmap_data,
    output logic [DW-1:0] pe_input_psum,
    input  logic [DW-1:0] pe_psum_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [EA-1:0] out_index
);

    localparam logic [WA-1:0] S_LAST = WA'(S - 1);
    localparam logic [EA-1:0] O_LAST = EA'(E - 1);

    feeder_state_t state;

    logic [DW-1:0] wt  [S];
    logic [DW-1:0] ifm [W];
    logic [DW-1:0] acc [E];

    logic [EA-1:0] o_cnt;
    logic [WA-1:0] s_cnt;
    logic [EA-1:0] k_cnt;
    logic          flush_cnt;
    logic          issue_valid;
    logic [EA-1:0] issue_idx;
    logic          tag_valid;
    logic [EA-1:0] tag_idx;

    logic          wrap_s;
    logic          last_pair;
    logic [WA-1:0] s_nxt;
    logic [EA-1:0] o_nxt;
    logic [IA-1:0] if_sel;
    logic [EA-1:0] k_nxt;
    logic [DW-1:0] acc_first;

    // next (o, s) pair; acc_first forwards a product landing on acc[0] this cycle
    always_comb begin
        wrap_s    = (s_cnt == S_LAST);
        last_pair = wrap_s && (o_cnt == O_LAST);
        s_nxt     = wrap_s ? {WA{1'b0}} : s_cnt + 1'b1;
        o_nxt     = wrap_s ? o_cnt + 1'b1 : o_cnt;
        if_sel    = IA'(o_nxt) + IA'(s_nxt);
        k_nxt     = k_cnt + 1'b1;
        acc_first = acc[0] + ((tag_valid && (tag_idx == {EA{1'b0}})) ? pe_psum_in : {DW{1'b0}});
    end

    pe_tag_pipe #(.IW(EA)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_idx    (issue_idx),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

    // operand buffers: writable only while idle, out-of-range addresses dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < S; i++) wt[i] <= {DW{1'b0}};
            for (int i = 0; i < W; i++) ifm[i] <= {DW{1'b0}};
        end else if (state == IDLE) begin
            if (wt_wr_en && (int'(wt_wr_addr) < S)) wt[wt_wr_addr] <= wt_wr_data;
            if (if_wr_en && (int'(if_wr_addr) < W)) ifm[if_wr_addr] <= if_wr_data;
        end
    end

    // per-output accumulators, wrapping modulo 2^DW
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < E; i++) acc[i] <= {DW{1'b0}};
        end else if ((state == IDLE) && start) begin
            for (int i = 0; i < E; i++) acc[i] <= {DW{1'b0}};
        end else if (tag_valid) begin
            acc[tag_idx] <= acc[tag_idx] + pe_psum_in;
        end
    end

    // sequencer; the first pair is registered on the accepting start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pe_mode        <= MODE_CLEAR;
            pe_filter_data <= {DW{1'b0}};
            pe_ifmap_data  <= {DW{1'b0}};
            o_cnt          <= {EA{1'b0}};
            s_cnt          <= {WA{1'b0}};
            k_cnt          <= {EA{1'b0}};
            flush_cnt      <= 1'b0;
            issue_valid    <= 1'b0;
            issue_idx      <= {EA{1'b0}};
            out_valid      <= 1'b0;
            out_data       <= {DW{1'b0}};
            out_index      <= {EA{1'b0}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= ISSUE;
                        busy           <= 1'b1;
                        o_cnt          <= {EA{1'b0}};
                        s_cnt          <= {WA{1'b0}};
                        k_cnt          <= {EA{1'b0}};
                        pe_mode        <= MODE_FILTER;
                        pe_filter_data <= wt[0];
                        pe_ifmap_data  <= ifm[0];
                        issue_valid    <= 1'b1;
                        issue_idx      <= {EA{1'b0}};
                    end
                end
                ISSUE: begin
                    if (last_pair) begin
                        state          <= FLUSH;
                        flush_cnt      <= 1'b0;
                        pe_mode        <= MODE_CLEAR;
                        pe_filter_data <= {DW{1'b0}};
                        pe_ifmap_data  <= {DW{1'b0}};
                        issue_valid    <= 1'b0;
                    end else begin
                        o_cnt          <= o_nxt;
                        s_cnt          <= s_nxt;
                        pe_filter_data <= wt[s_nxt];
                        pe_ifmap_data  <= ifm[if_sel];
                        issue_valid    <= 1'b1;
                        issue_idx      <= o_nxt;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= acc_first;
                        out_index <= {EA{1'b0}};
                        k_cnt     <= {EA{1'b0}};
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (k_cnt == O_LAST) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            k_cnt     <= k_nxt;
                            out_index <= k_nxt;
                            out_data  <= acc[k_nxt];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pe_input_psum = {DW{1'b0}};

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder with a behavioural 2-cycle multiplier PE.
module tb_pe_row_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wt_wr_en;
    logic [1:0]  wt_wr_addr;
    logic [31:0] wt_wr_data;
    logic        if_wr_en;
    logic [2:0]  if_wr_addr;
    logic [31:0] if_wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  pe_mode;
    logic [31:0] pe_filter_data;
    logic [31:0] pe_ifmap_data;
    logic [31:0] pe_input_psum;
    logic [31:0] pe_psum_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_index;

    logic [31:0] pe_p1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            name;
        logic [2:0][31:0] w;
        logic [7:0][31:0] f;
        logic [5:0][31:0] exp;
    } vec_t;

    vec_t vecs [4];

    localparam logic [2:0][31:0] W_BASIC = {32'd3, 32'd2, 32'd1};
    localparam logic [7:0][31:0] F_ASC   = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [5:0][31:0] E_BASIC = {32'd44, 32'd38, 32'd32, 32'd26, 32'd20, 32'd14};

    always #5 clk = ~clk;

    pe_row_feeder #(.DW(32), .S(3), .W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .wt_wr_en       (wt_wr_en),
        .wt_wr_addr     (wt_wr_addr),
        .wt_wr_data     (wt_wr_data),
        .if_wr_en       (if_wr_en),
        .if_wr_addr     (if_wr_addr),
        .if_wr_data     (if_wr_data),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pe_mode        (pe_mode),
        .pe_filter_data (pe_filter_data),
        .pe_ifmap_data  (pe_ifmap_data),
        .pe_input_psum  (pe_input_psum),
        .pe_psum_in     (pe_psum_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_index      (out_index)
    );

    // PE model: product truncated to 32 bits, visible two cycles after issue
    always @(posedge clk) begin
        pe_p1      <= (pe_mode == 2'b00) ? pe_filter_data * pe_ifmap_data : 32'd0;
        pe_psum_in <= pe_p1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic load(input logic [2:0][31:0] w, input logic [7:0][31:0] f);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start      = 1'b0;
            if_wr_en   = 1'b1;
            if_wr_addr = 3'(i);
            if_wr_data = f[i];
            wt_wr_en   = (i < 3);
            wt_wr_addr = 2'(i);
            wt_wr_data = (i < 3) ? w[i] : 32'd0;
        end
    endtask

    // one pass from start to done; returns at the negedge of the done cycle
    task automatic run_pass(input string name, input logic [5:0][31:0] exp,
                            input int stall_idx, input int stall_n, input bit inject);
        int n, done_at, mode_cnt, got_n, stall_left;
        logic [31:0] got_d [8];
        logic [31:0] got_i [8];
        n = 0; done_at = -1; mode_cnt = 0; got_n = 0; stall_left = stall_n;
        for (int i = 0; i < 8; i++) begin
            got_d[i] = 32'd0;
            got_i[i] = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        start = 1'b1; wt_wr_en = 1'b0; if_wr_en = 1'b0; out_ready = 1'b1;
        while (done_at < 0 && n < 200) begin
            @(negedge clk);
            n++;
            start = 1'b0; wt_wr_en = 1'b0;
            if (inject && n == 5) begin
                start = 1'b1; wt_wr_en = 1'b1; wt_wr_addr = 2'd0; wt_wr_data = 32'd99;
            end
            if (n == 1) check({name, " busy_rise"}, 32'(busy), 32'd1);
            if (pe_mode == 2'b00) mode_cnt++;
            if (out_valid && stall_left > 0 && out_index == 3'(stall_idx)) begin
                out_ready = 1'b0;
                stall_left--;
                check({name, " hold_data"}, out_data, exp[stall_idx]);
                check({name, " hold_idx"}, 32'(out_index), 32'(stall_idx));
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && got_n < 8) begin
                got_d[got_n] = out_data;
                got_i[got_n] = 32'(out_index);
                got_n++;
            end
            if (done) begin
                done_at = n;
                check({name, " busy_fall"}, 32'(busy), 32'd0);
            end
        end
        out_ready = 1'b1;
        if (done_at < 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, n);
        end
        check({name, " done_cycle"}, 32'(done_at), 32'(27 + stall_n));
        check({name, " mode00_cycles"}, 32'(mode_cnt), 32'd18);
        check({name, " out_count"}, 32'(got_n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s idx%0d", name, i), got_i[i], 32'(i));
            check($sformatf("%s data%0d", name, i), got_d[i], exp[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic", W_BASIC, F_ASC, E_BASIC};
        vecs[1] = '{"wrap", {32'd1, 32'd1, 32'd1},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF},
                    {32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd1}};
        vecs[2] = '{"desc", {32'd4, 32'd3, 32'd2},
                    {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                    {32'd16, 32'd25, 32'd34, 32'd43, 32'd52, 32'd61}};
        vecs[3] = '{"neg_wt", {32'd1, 32'd0, 32'hFFFF_FFFF}, F_ASC,
                    {32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2}};

        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        wt_wr_en = 1'b0; wt_wr_addr = 2'd0; wt_wr_data = 32'd0;
        if_wr_en = 1'b0; if_wr_addr = 3'd0; if_wr_data = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst pe_mode", 32'(pe_mode), 32'd3);
        check("rst pe_filter", pe_filter_data, 32'd0);
        check("rst pe_ifmap", pe_ifmap_data, 32'd0);
        check("rst pe_input_psum", pe_input_psum, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_index", 32'(out_index), 32'd0);

        for (int v = 0; v < 4; v++) begin
            load(vecs[v].w, vecs[v].f);
            run_pass(vecs[v].name, vecs[v].exp, 0, 0, 1'b0);
        end

        // backpressure on idx 2 for three cycles
        load(W_BASIC, F_ASC);
        run_pass("backpressure", E_BASIC, 2, 3, 1'b0);

        // start and weight write during ISSUE must be ignored
        run_pass("ignored", E_BASIC, 0, 0, 1'b1);
        run_pass("ignored_rerun", E_BASIC, 0, 0, 1'b0);

        // back-to-back: change one tap in the done cycle, start the cycle after
        load({32'd7, 32'd0, 32'd0}, F_ASC);
        run_pass("b2b_first", {32'd56, 32'd49, 32'd42, 32'd35, 32'd28, 32'd21}, 0, 0, 1'b0);
        wt_wr_en = 1'b1; wt_wr_addr = 2'd2; wt_wr_data = 32'd1;
        run_pass("b2b_second", {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3}, 0, 0, 1'b0);

        // asynchronous reset in ISSUE cycle 5
        load(W_BASIC, F_ASC);
        @(negedge clk);
        start = 1'b1; wt_wr_en = 1'b0; if_wr_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset busy", 32'(busy), 32'd0);
        check("mid_reset pe_mode", 32'(pe_mode), 32'd3);
        check("mid_reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_pass("after_reset_cleared", {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0, 0, 1'b0);
        load(W_BASIC, F_ASC);
        run_pass("after_reset_reload", E_BASIC, 0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
